// File: rtl/decimal_entry_assembler_if.sv
// Keypad-entry bus: digit/command strobes in, live and committed values out.
// The master drives the strobes; the slave (the assembler) drives the results.
interface decimal_entry_assembler_if #(
  parameter int W = 10
);
  logic [3:0]   din;
  logic         din_vld;
  logic         bksp;
  logic         enter;
  logic         clr;
  logic [W-1:0] acc;
  logic [1:0]   count;
  logic [W-1:0] value;
  logic         done;
  logic         err;

  modport master (
    output din, din_vld, bksp, enter, clr,
    input  acc, count, value, done, err
  );

  modport slave (
    input  din, din_vld, bksp, enter, clr,
    output acc, count, value, done, err
  );
endinterface

// File: rtl/decimal_entry_assembler.sv
// Builds a binary number from MSD-first decimal keypad digits; one event per cycle,
// priority CLR > ENTER > BKSP > digit; all outputs registered, 1-cycle latency.
module decimal_entry_assembler #(
  parameter int NDIG = 3,
  parameter int W    = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  decimal_entry_assembler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_FULL, S_DONE} state_t;

  state_t       state_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] value_q;
  logic [1:0]   count_q;
  logic         done_q;
  logic         err_q;

  logic [W-1:0] acc_dig_d;
  logic [W-1:0] acc_div_d;
  logic [1:0]   count_inc_d;
  logic [1:0]   count_dec_d;
  logic         din_legal;

  // Widened before truncation; the NDIG bound keeps the true result below 2^W.
  assign acc_dig_d   = W'((W+4)'(acc_q) * (W+4)'(10) + (W+4)'(bus.din));
  assign acc_div_d   = acc_q / W'(10);
  assign count_inc_d = count_q + 2'd1;
  assign count_dec_d = count_q - 2'd1;
  assign din_legal   = (bus.din <= 4'd9);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      value_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.clr) begin
        state_q <= S_IDLE;
        acc_q   <= '0;
        count_q <= '0;
        done_q  <= 1'b0;
      end else if (bus.enter) begin
        case (state_q)
          S_ENTRY, S_FULL: begin
            value_q <= acc_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
          S_IDLE:  err_q <= 1'b1;
          default: ;
        endcase
      end else if (bus.bksp) begin
        // In DONE the committed entry is still held, so it is edited like FULL.
        if (state_q != S_IDLE) begin
          acc_q   <= acc_div_d;
          count_q <= count_dec_d;
          done_q  <= 1'b0;
          state_q <= (count_dec_d == 2'd0) ? S_IDLE : S_ENTRY;
        end
      end else if (bus.din_vld) begin
        if (!din_legal) begin
          err_q <= 1'b1;
        end else begin
          case (state_q)
            S_IDLE, S_ENTRY: begin
              acc_q   <= acc_dig_d;
              count_q <= count_inc_d;
              state_q <= (count_inc_d == 2'(NDIG)) ? S_FULL : S_ENTRY;
            end
            S_FULL:  err_q <= 1'b1;
            default: begin
              acc_q   <= W'(bus.din);
              count_q <= 2'd1;
              done_q  <= 1'b0;
              state_q <= (NDIG == 1) ? S_FULL : S_ENTRY;
            end
          endcase
        end
      end
    end
  end

  assign bus.acc   = acc_q;
  assign bus.count = count_q;
  assign bus.value = value_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_decimal_entry_assembler.sv
// Directed table of keypad events with hand-computed results, plus an async-reset sequence.
module tb_decimal_entry_assembler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  decimal_entry_assembler_if #(.W(10)) bus ();

  decimal_entry_assembler #(.NDIG(3), .W(10)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       enter;
    logic       bksp;
    logic       vld;
    logic [3:0] din;
    logic [9:0] acc;
    logic [1:0] cnt;
    logic [9:0] val;
    logic       dn;
    logic       er;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic c, e, b, v, input logic [3:0] d,
                     input logic [9:0] a, input logic [1:0] n,
                     input logic [9:0] val, input logic dn, er);
    vec_t t;
    t.clr = c; t.enter = e; t.bksp = b; t.vld = v; t.din = d;
    t.acc = a; t.cnt = n; t.val = val; t.dn = dn; t.er = er;
    tv.push_back(t);
  endtask

  task automatic check(input string name, input logic [9:0] a, input logic [1:0] n,
                       input logic [9:0] val, input logic dn, er);
    checks++;
    if (bus.acc !== a || bus.count !== n || bus.value !== val || bus.done !== dn || bus.err !== er) begin
      errors++;
      $display("FAIL %s: got acc=%0d count=%0d value=%0d done=%b err=%b, expected acc=%0d count=%0d value=%0d done=%b err=%b",
               name, bus.acc, bus.count, bus.value, bus.done, bus.err, a, n, val, dn, er);
    end
  endtask

  task automatic drive(input logic c, e, b, v, input logic [3:0] d);
    @(negedge clk);
    bus.clr = c; bus.enter = e; bus.bksp = b; bus.din_vld = v; bus.din = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.clr = 1'b0; bus.enter = 1'b0; bus.bksp = 1'b0; bus.din_vld = 1'b0; bus.din = 4'd0;
  endtask

  initial begin
    bus.clr = 1'b0; bus.enter = 1'b0; bus.bksp = 1'b0; bus.din_vld = 1'b0; bus.din = 4'd0;

    //   clr enter bksp vld din   acc  cnt val  dn er
    add(0, 0, 0, 1, 4'd1,   1,   1,   0,  0, 0);
    add(0, 0, 0, 1, 4'd2,  12,   2,   0,  0, 0);
    add(0, 0, 0, 1, 4'd3, 123,   3,   0,  0, 0);
    add(0, 1, 0, 0, 4'd0, 123,   3, 123,  1, 0);
    add(0, 1, 0, 0, 4'd0, 123,   3, 123,  1, 0);   // ENTER in DONE ignored
    add(0, 0, 0, 1, 4'd7,   7,   1, 123,  0, 0);   // new number from DONE
    add(1, 1, 0, 0, 4'd0,   0,   0, 123,  0, 0);   // CLR beats ENTER
    add(0, 0, 0, 1, 4'd4,   4,   1, 123,  0, 0);
    add(0, 0, 0, 1, 4'd5,  45,   2, 123,  0, 0);
    add(0, 0, 0, 1, 4'd6, 456,   3, 123,  0, 0);
    add(0, 0, 0, 1, 4'd4, 456,   3, 123,  0, 1);   // digit in FULL rejected
    add(0, 0, 0, 0, 4'd0, 456,   3, 123,  0, 0);   // ERR lasts one cycle
    add(0, 1, 0, 1, 4'd5, 456,   3, 456,  1, 0);   // ENTER beats digit
    add(0, 0, 1, 0, 4'd0,  45,   2, 456,  0, 0);   // BKSP in DONE
    add(1, 0, 0, 0, 4'd0,   0,   0, 456,  0, 0);
    add(0, 0, 1, 0, 4'd0,   0,   0, 456,  0, 0);   // BKSP in IDLE: nothing
    add(0, 1, 0, 0, 4'd0,   0,   0, 456,  0, 1);   // ENTER in IDLE rejected
    add(0, 0, 0, 1, 4'd5,   5,   1, 456,  0, 0);
    add(0, 0, 0, 1, 4'hA,   5,   1, 456,  0, 1);   // illegal BCD
    add(1, 0, 0, 0, 4'd0,   0,   0, 456,  0, 0);
    add(0, 0, 0, 1, 4'd9,   9,   1, 456,  0, 0);
    add(0, 0, 0, 1, 4'd9,  99,   2, 456,  0, 0);
    add(0, 0, 0, 1, 4'd9, 999,   3, 456,  0, 0);
    add(0, 1, 0, 0, 4'd0, 999,   3, 999,  1, 0);
    add(0, 0, 0, 1, 4'hF, 999,   3, 999,  1, 1);   // illegal digit in DONE
    add(1, 0, 0, 0, 4'd0,   0,   0, 999,  0, 0);
    add(0, 0, 0, 1, 4'd1,   1,   1, 999,  0, 0);
    add(0, 0, 0, 1, 4'd2,  12,   2, 999,  0, 0);
    add(0, 0, 0, 1, 4'd3, 123,   3, 999,  0, 0);
    add(0, 0, 1, 0, 4'd0,  12,   2, 999,  0, 0);
    add(0, 0, 1, 0, 4'd0,   1,   1, 999,  0, 0);
    add(0, 0, 0, 1, 4'd4,  14,   2, 999,  0, 0);
    add(0, 0, 1, 1, 4'd7,   1,   1, 999,  0, 0);   // BKSP beats digit
    add(0, 0, 1, 0, 4'd0,   0,   0, 999,  0, 0);   // back to IDLE
    add(0, 0, 1, 0, 4'd0,   0,   0, 999,  0, 0);
    add(0, 0, 0, 1, 4'hC,   0,   0, 999,  0, 1);   // illegal digit in IDLE
    add(0, 0, 0, 1, 4'd0,   0,   1, 999,  0, 0);   // leading zero counts

    #1;
    check("reset", 10'd0, 2'd0, 10'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      bus.clr = tv[i].clr; bus.enter = tv[i].enter; bus.bksp = tv[i].bksp;
      bus.din_vld = tv[i].vld; bus.din = tv[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tv[i].acc, tv[i].cnt, tv[i].val, tv[i].dn, tv[i].er);
    end
    @(negedge clk);
    bus.clr = 1'b0; bus.enter = 1'b0; bus.bksp = 1'b0; bus.din_vld = 1'b0; bus.din = 4'd0;

    // Async reset between the 2nd and 3rd digit, asserted mid-cycle.
    drive(1, 0, 0, 0, 4'd0);
    drive(0, 0, 0, 1, 4'd6);
    drive(0, 0, 0, 1, 4'd2);
    #1;
    check("pre_reset", 10'd62, 2'd2, 10'd999, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 10'd0, 2'd0, 10'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 10'd0, 2'd0, 10'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b1; bus.din = 4'd8;
    @(posedge clk);
    #1;
    check("after_reset", 10'd8, 2'd1, 10'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.din_vld = 1'b0; bus.din = 4'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang, expected finish");
    $fatal(1);
  end

endmodule
